decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
- Instruction-decode/issue stage sitting directly downstream of the Registers block in the pipelined MIPS datapath.
- Drives the Registers read addresses from the IF/ID instruction and captures the returned operands.
- Bypasses the same-cycle writeback, detects load-use hazards, and holds the ID/EX pipeline register with a valid/ready handshake toward EX.

Parameters:
DATA_WIDTH, 32, operand/instruction width
ADDR_WIDTH, 5, register address width
STALL_CNT_WIDTH, 16, width of saturating stall counter

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
ifidValid  in  1  IF/ID holds a valid instruction
instruction  in  32  IF/ID instruction
pcPlus4  in  32  IF/ID PC+4
readAddress1  out  5  to Registers, = instruction[25:21] (combinational)
readAddress2  out  5  to Registers, = instruction[20:16] (combinational)
readData1  in  32  from Registers
readData2  in  32  from Registers
wbRegWrite  in  1  WB stage write enable (same signal feeding Registers)
wbWriteAddress  in  5  WB destination
wbWriteData  in  32  WB data
flush  in  1  taken branch/jump from EX; kill ID contents
exReady  in  1  EX accepts ID/EX contents this cycle
stall  out  1  hold PC and IF/ID
exValid  out  1  ID/EX valid
exOperand1, exOperand2  out  32 each  bypassed rs/rt values
exImmediate  out  32  sign-extended instruction[15:0]
exPcPlus4  out  32
exOpcode  out  6;  exFunct  out  6
exRs, exRt, exWriteAddress  out  5 each
exMemRead, exRegWrite  out  1 each
stallCount  out  16  saturating count of stall cycles

Behaviour:
- Reset (async): all ID/EX outputs and stallCount = 0; exValid = 0.
- Bypass: operand1 = wbWriteData if wbRegWrite & wbWriteAddress==rs & rs!=0, else readData1; same for operand2/rt. Register $0 is never bypassed and always reads 0.
- Decode:
  - exMemRead = (opcode==0x23).
  - exRegWrite = 1 for R-type (funct!=0x08), addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23.
  - Otherwise exRegWrite = 0. exRegWrite is forced 0 when the destination is 0.
  - exWriteAddress = rd for opcode 0x00, else rt.
- loadUse = exValid & exMemRead & exWriteAddress!=0 & (exWriteAddress==rs | exWriteAddress==rt). The rt compare is conservative and applies to every opcode.
- Per-cycle priority at posedge:
  1. flush: exValid <= 0, other fields don't-care.
  2. !exReady: ID/EX holds all fields.
  3. ifidValid & loadUse: bubble, exValid <= 0.
  4. Otherwise: capture decode, exValid <= ifidValid.
- stall = !flush & (!exReady | (ifidValid & loadUse)), combinational.
- Latency: one cycle from IF/ID to ID/EX. A load-use hazard costs exactly one bubble.
- stallCount increments on each cycle with stall=1 and saturates at 0xFFFF.
- Reset mid-stall clears everything; no hazard state persists.
- flush and loadUse together: flush wins and stall = 0.

Decomposition:
- Shared package mips_pkg: opcode/funct constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, FN_JR), instruction field slice positions.
- Sub-module bypass_mux: WB-to-ID operand bypass, instantiated twice.

Test Plan:
- Reset: assert reset mid-run → exValid=0, stallCount=0 immediately, without waiting for clk.
- Bypass: Registers returns 0x00000000 for $2 while wbRegWrite=1, wbWriteAddress=2, wbWriteData=0x12345678, instruction add $3,$2,$2 → next edge exOperand1=exOperand2=0x12345678, exWriteAddress=3, exRegWrite=1.
- $0 guard: wbWriteAddress=0, wbWriteData=0xFFFFFFFF, instruction reads $0 → exOperand1=0.
- Load-use: lw $5,0($1) issued, then add $6,$5,$4 → stall=1 for one cycle, bubble (exValid=0), add issues next cycle, stallCount=1.
- Backpressure: exReady=0 for 3 cycles → ID/EX fields unchanged, stall=1 each cycle, stallCount +3. Then exReady=1 → advance.
- Flush: flush=1 with exReady=0 and a pending load-use → exValid=0 next edge, stall=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, field positions and the ID/EX payload.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned IMM_W   = 16;

    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned FN_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
    localparam logic [FN_W-1:0]  FN_JR    = 6'h08;

    // Contents of the ID/EX pipeline register (valid bit kept separately).
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [FN_W-1:0]   funct;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wr_addr;
        logic              mem_read;
        logic              reg_write;
        logic [XLEN-1:0]   operand1;
        logic [XLEN-1:0]   operand2;
        logic [XLEN-1:0]   immediate;
        logic [XLEN-1:0]   pc_plus4;
    } idex_t;

    // True when the opcode/funct pair writes a register (before the $0 guard).
    function automatic logic writes_reg(input logic [OPC_W-1:0] opcode,
                                        input logic [FN_W-1:0]  funct);
        logic wr;
        wr = 1'b0;
        case (opcode)
            OP_RTYPE: wr = (funct != FN_JR);
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: wr = 1'b1;
            OP_SW:    wr = 1'b0;
            default:  wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/bypass_mux.sv
// WB-to-ID operand bypass for one register read port.
module bypass_mux #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    output logic [DATA_WIDTH-1:0] operand_c
);

    // $0 is hard-wired to zero and never takes the bypass.
    always_comb begin
        operand_c = read_data;
        if (read_addr == '0) begin
            operand_c = '0;
        end else if (wb_reg_write && (wb_write_addr == read_addr)) begin
            operand_c = wb_write_data;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// MIPS decode/issue stage: operand fetch, WB bypass, load-use bubble, ID/EX register.
module decode_issue_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ifidValid,
    input  logic [DATA_WIDTH-1:0]      instruction,
    input  logic [DATA_WIDTH-1:0]      pcPlus4,
    output logic [ADDR_WIDTH-1:0]      readAddress1,
    output logic [ADDR_WIDTH-1:0]      readAddress2,
    input  logic [DATA_WIDTH-1:0]      readData1,
    input  logic [DATA_WIDTH-1:0]      readData2,
    input  logic                       wbRegWrite,
    input  logic [ADDR_WIDTH-1:0]      wbWriteAddress,
    input  logic [DATA_WIDTH-1:0]      wbWriteData,
    input  logic                       flush,
    input  logic                       exReady,
    output logic                       stall,
    output logic                       exValid,
    output logic [DATA_WIDTH-1:0]      exOperand1,
    output logic [DATA_WIDTH-1:0]      exOperand2,
    output logic [DATA_WIDTH-1:0]      exImmediate,
    output logic [DATA_WIDTH-1:0]      exPcPlus4,
    output logic [OPC_W-1:0]           exOpcode,
    output logic [FN_W-1:0]            exFunct,
    output logic [ADDR_WIDTH-1:0]      exRs,
    output logic [ADDR_WIDTH-1:0]      exRt,
    output logic [ADDR_WIDTH-1:0]      exWriteAddress,
    output logic                       exMemRead,
    output logic                       exRegWrite,
    output logic [STALL_CNT_WIDTH-1:0] stallCount
);

    logic [OPC_W-1:0]  opcode;
    logic [FN_W-1:0]   funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;

    logic [DATA_WIDTH-1:0] operand1_c;
    logic [DATA_WIDTH-1:0] operand2_c;
    logic                  load_use_c;
    idex_t                 dec_c;

    idex_t                      idex_q, idex_d;
    logic                       valid_q, valid_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    assign opcode = instruction[OPC_LSB +: OPC_W];
    assign funct  = instruction[FN_LSB +: FN_W];
    assign rs     = instruction[RS_LSB +: REG_AW];
    assign rt     = instruction[RT_LSB +: REG_AW];
    assign rd     = instruction[RD_LSB +: REG_AW];

    assign readAddress1 = rs;
    assign readAddress2 = rt;

    bypass_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bypass_rs (
        .read_addr     (rs),
        .read_data     (readData1),
        .wb_reg_write  (wbRegWrite),
        .wb_write_addr (wbWriteAddress),
        .wb_write_data (wbWriteData),
        .operand_c     (operand1_c)
    );

    bypass_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bypass_rt (
        .read_addr     (rt),
        .read_data     (readData2),
        .wb_reg_write  (wbRegWrite),
        .wb_write_addr (wbWriteAddress),
        .wb_write_data (wbWriteData),
        .operand_c     (operand2_c)
    );

    // Decode the IF/ID instruction into the ID/EX payload.
    always_comb begin
        dec_c           = '0;
        dec_c.opcode    = opcode;
        dec_c.funct     = funct;
        dec_c.rs        = rs;
        dec_c.rt        = rt;
        dec_c.wr_addr   = (opcode == OP_RTYPE) ? rd : rt;
        dec_c.mem_read  = (opcode == OP_LW);
        dec_c.reg_write = writes_reg(opcode, funct) && (dec_c.wr_addr != '0);
        dec_c.operand1  = operand1_c;
        dec_c.operand2  = operand2_c;
        dec_c.immediate = {{(XLEN - IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
        dec_c.pc_plus4  = pcPlus4;
    end

    // Load in EX whose destination feeds this instruction; rt compared for every opcode.
    assign load_use_c = valid_q && idex_q.mem_read && (idex_q.wr_addr != '0) &&
                        ((idex_q.wr_addr == rs) || (idex_q.wr_addr == rt));

    assign stall = !flush && (!exReady || (ifidValid && load_use_c));

    // Next ID/EX contents by priority: flush, backpressure hold, bubble, advance.
    always_comb begin
        idex_d      = idex_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!exReady) begin
            valid_d = valid_q;
        end else if (ifidValid && load_use_c) begin
            valid_d = 1'b0;
        end else begin
            idex_d  = dec_c;
            valid_d = ifidValid;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    // ID/EX register and stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q      <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign exValid        = valid_q;
    assign exOperand1     = idex_q.operand1;
    assign exOperand2     = idex_q.operand2;
    assign exImmediate    = idex_q.immediate;
    assign exPcPlus4      = idex_q.pc_plus4;
    assign exOpcode       = idex_q.opcode;
    assign exFunct        = idex_q.funct;
    assign exRs           = idex_q.rs;
    assign exRt           = idex_q.rt;
    assign exWriteAddress = idex_q.wr_addr;
    assign exMemRead      = idex_q.mem_read;
    assign exRegWrite     = idex_q.reg_write;
    assign stallCount     = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Table-driven scoreboard bench for decode_issue_stage.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifidValid;
    logic [31:0] instruction;
    logic [31:0] pcPlus4;
    logic [4:0]  readAddress1, readAddress2;
    logic [31:0] readData1, readData2;
    logic        wbRegWrite;
    logic [4:0]  wbWriteAddress;
    logic [31:0] wbWriteData;
    logic        flush;
    logic        exReady;
    logic        stall;
    logic        exValid;
    logic [31:0] exOperand1, exOperand2, exImmediate, exPcPlus4;
    logic [5:0]  exOpcode, exFunct;
    logic [4:0]  exRs, exRt, exWriteAddress;
    logic        exMemRead, exRegWrite;
    logic [15:0] stallCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ifidValid      (ifidValid),
        .instruction    (instruction),
        .pcPlus4        (pcPlus4),
        .readAddress1   (readAddress1),
        .readAddress2   (readAddress2),
        .readData1      (readData1),
        .readData2      (readData2),
        .wbRegWrite     (wbRegWrite),
        .wbWriteAddress (wbWriteAddress),
        .wbWriteData    (wbWriteData),
        .flush          (flush),
        .exReady        (exReady),
        .stall          (stall),
        .exValid        (exValid),
        .exOperand1     (exOperand1),
        .exOperand2     (exOperand2),
        .exImmediate    (exImmediate),
        .exPcPlus4      (exPcPlus4),
        .exOpcode       (exOpcode),
        .exFunct        (exFunct),
        .exRs           (exRs),
        .exRt           (exRt),
        .exWriteAddress (exWriteAddress),
        .exMemRead      (exMemRead),
        .exRegWrite     (exRegWrite),
        .stallCount     (stallCount)
    );

    // Register file model: $n holds 0x1000_0000 + n, $0 reads zero.
    function automatic logic [31:0] rv(input logic [4:0] n);
        return (n == 5'd0) ? 32'h0 : 32'h1000_0000 + {27'd0, n};
    endfunction

    assign readData1 = rv(instruction[25:21]);
    assign readData2 = rv(instruction[20:16]);

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic        ifid, rdy, fl, we;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        e_stall, cap, chk, e_valid;
        logic [31:0] e_op1, e_op2;
        logic [4:0]  e_wa;
        logic        e_rw, e_mr;
    } vec_t;

    typedef struct {
        logic        valid, chk;
        logic [31:0] op1, op2, imm, pc;
        logic [5:0]  opc, fn;
        logic [4:0]  rs, rt, wa;
        logic        rw, mr;
        logic [15:0] cnt;
    } exp_t;

    function automatic vec_t mk(input logic [31:0] instr, input logic ifid, input logic rdy,
                                input logic fl, input logic we, input logic [4:0] wba,
                                input logic [31:0] wbd, input logic e_stall, input logic cap,
                                input logic chk, input logic e_valid, input logic [31:0] e_op1,
                                input logic [31:0] e_op2, input logic [4:0] e_wa,
                                input logic e_rw, input logic e_mr);
        vec_t v;
        v.instr = instr; v.ifid = ifid; v.rdy = rdy; v.fl = fl; v.we = we; v.wba = wba;
        v.wbd = wbd; v.e_stall = e_stall; v.cap = cap; v.chk = chk; v.e_valid = e_valid;
        v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_wa = e_wa; v.e_rw = e_rw; v.e_mr = e_mr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    vec_t vecs[28];
    exp_t sb_q[$];
    exp_t last;
    exp_t cur;
    exp_t got;
    logic [15:0] model_cnt;

    initial begin
        vecs[0]  = mk(r_ins(2, 2, 3, 6'h20), 1, 1, 0, 1, 2, 32'h1234_5678, 0, 1, 1, 1, 32'h1234_5678, 32'h1234_5678, 3, 1, 0);
        vecs[1]  = mk(i_ins(6'h08, 0, 8, 16'h0005), 1, 1, 0, 1, 0, 32'hFFFF_FFFF, 0, 1, 1, 1, 32'h0, rv(8), 8, 1, 0);
        vecs[2]  = mk(i_ins(6'h2B, 1, 4, 16'h0008), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(1), rv(4), 4, 0, 0);
        vecs[3]  = mk(r_ins(31, 0, 0, 6'h08), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(31), 32'h0, 0, 0, 0);
        vecs[4]  = mk(r_ins(1, 2, 0, 6'h20), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(1), rv(2), 0, 0, 0);
        vecs[5]  = mk(i_ins(6'h23, 1, 5, 16'h0000), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(1), rv(5), 5, 1, 1);
        vecs[6]  = mk(r_ins(5, 4, 6, 6'h20), 1, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        vecs[7]  = mk(r_ins(5, 4, 6, 6'h20), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(5), rv(4), 6, 1, 0);
        vecs[8]  = mk(i_ins(6'h0D, 3, 9, 16'h00FF), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(3), rv(9), 9, 1, 0);
        vecs[9]  = mk(i_ins(6'h0C, 12, 11, 16'h0001), 1, 0, 0, 0, 0, 32'h0, 1, 0, 1, 1, rv(3), rv(9), 9, 1, 0);
        vecs[10] = mk(i_ins(6'h0C, 12, 11, 16'h0001), 1, 0, 0, 0, 0, 32'h0, 1, 0, 1, 1, rv(3), rv(9), 9, 1, 0);
        vecs[11] = mk(i_ins(6'h0C, 12, 11, 16'h0001), 1, 0, 0, 0, 0, 32'h0, 1, 0, 1, 1, rv(3), rv(9), 9, 1, 0);
        vecs[12] = mk(i_ins(6'h0C, 12, 11, 16'h0001), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(12), rv(11), 11, 1, 0);
        vecs[13] = mk(i_ins(6'h23, 1, 5, 16'h0000), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(1), rv(5), 5, 1, 1);
        vecs[14] = mk(r_ins(5, 4, 6, 6'h20), 1, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        vecs[15] = mk(i_ins(6'h0A, 14, 13, 16'hFFFF), 0, 1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        vecs[16] = mk(i_ins(6'h0A, 14, 13, 16'hFFFF), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(14), rv(13), 13, 1, 0);
        vecs[17] = mk(i_ins(6'h0F, 0, 15, 16'h8000), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, 32'h0, rv(15), 15, 1, 0);
        vecs[18] = mk(r_ins(17, 18, 16, 6'h20), 1, 1, 0, 1, 18, 32'hCAFE_F00D, 0, 1, 1, 1, rv(17), 32'hCAFE_F00D, 16, 1, 0);
        vecs[19] = mk(r_ins(17, 18, 16, 6'h22), 1, 1, 0, 0, 17, 32'hDEAD_BEEF, 0, 1, 1, 1, rv(17), rv(18), 16, 1, 0);
        vecs[20] = mk(i_ins(6'h23, 7, 20, 16'h0004), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(7), rv(20), 20, 1, 1);
        vecs[21] = mk(i_ins(6'h08, 3, 20, 16'h0001), 1, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        vecs[22] = mk(i_ins(6'h08, 3, 20, 16'h0001), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(3), rv(20), 20, 1, 0);
        vecs[23] = mk(i_ins(6'h23, 1, 0, 16'h0000), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(1), 32'h0, 0, 0, 1);
        vecs[24] = mk(r_ins(0, 0, 2, 6'h20), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, 32'h0, 32'h0, 2, 1, 0);
        vecs[25] = mk(i_ins(6'h23, 1, 5, 16'h0000), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(1), rv(5), 5, 1, 1);
        vecs[26] = mk(r_ins(5, 4, 6, 6'h20), 0, 1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        vecs[27] = mk(r_ins(5, 4, 6, 6'h20), 1, 1, 0, 0, 0, 32'h0, 0, 1, 1, 1, rv(5), rv(4), 6, 1, 0);

        reset = 1'b1; ifidValid = 1'b0; instruction = 32'h0; pcPlus4 = 32'h0;
        wbRegWrite = 1'b0; wbWriteAddress = 5'd0; wbWriteData = 32'h0;
        flush = 1'b0; exReady = 1'b1;
        model_cnt = 16'd0;
        last = '{default: '0};

        @(posedge clk); #2;
        chk("reset_exValid", {31'd0, exValid}, 32'd0);
        chk("reset_stallCount", {16'd0, stallCount}, 32'd0);
        chk("reset_exOperand1", exOperand1, 32'd0);
        chk("reset_exRegWrite", {31'd0, exRegWrite}, 32'd0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            instruction    = vecs[i].instr;
            ifidValid      = vecs[i].ifid;
            exReady        = vecs[i].rdy;
            flush          = vecs[i].fl;
            wbRegWrite     = vecs[i].we;
            wbWriteAddress = vecs[i].wba;
            wbWriteData    = vecs[i].wbd;
            pcPlus4        = 32'h0000_0400 + 32'(i * 4);
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_readAddress1", i), {27'd0, readAddress1}, {27'd0, vecs[i].instr[25:21]});
            chk($sformatf("v%0d_readAddress2", i), {27'd0, readAddress2}, {27'd0, vecs[i].instr[20:16]});
            if (vecs[i].e_stall) model_cnt = model_cnt + 16'd1;
            if (vecs[i].cap) begin
                last.op1 = vecs[i].e_op1;
                last.op2 = vecs[i].e_op2;
                last.wa  = vecs[i].e_wa;
                last.rw  = vecs[i].e_rw;
                last.mr  = vecs[i].e_mr;
                last.imm = {{16{vecs[i].instr[15]}}, vecs[i].instr[15:0]};
                last.pc  = pcPlus4;
                last.opc = vecs[i].instr[31:26];
                last.fn  = vecs[i].instr[5:0];
                last.rs  = vecs[i].instr[25:21];
                last.rt  = vecs[i].instr[20:16];
            end
            cur       = last;
            cur.valid = vecs[i].e_valid;
            cur.chk   = vecs[i].chk;
            cur.cnt   = model_cnt;
            sb_q.push_back(cur);

            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d_scoreboard_empty", i), 32'd1, 32'd0);
            end else begin
                got = sb_q.pop_front();
                chk($sformatf("v%0d_exValid", i), {31'd0, exValid}, {31'd0, got.valid});
                chk($sformatf("v%0d_stallCount", i), {16'd0, stallCount}, {16'd0, got.cnt});
                if (got.chk) begin
                    chk($sformatf("v%0d_exOperand1", i), exOperand1, got.op1);
                    chk($sformatf("v%0d_exOperand2", i), exOperand2, got.op2);
                    chk($sformatf("v%0d_exWriteAddress", i), {27'd0, exWriteAddress}, {27'd0, got.wa});
                    chk($sformatf("v%0d_exRegWrite", i), {31'd0, exRegWrite}, {31'd0, got.rw});
                    chk($sformatf("v%0d_exMemRead", i), {31'd0, exMemRead}, {31'd0, got.mr});
                    chk($sformatf("v%0d_exImmediate", i), exImmediate, got.imm);
                    chk($sformatf("v%0d_exPcPlus4", i), exPcPlus4, got.pc);
                    chk($sformatf("v%0d_exOpcode", i), {26'd0, exOpcode}, {26'd0, got.opc});
                    chk($sformatf("v%0d_exFunct", i), {26'd0, exFunct}, {26'd0, got.fn});
                    chk($sformatf("v%0d_exRs", i), {27'd0, exRs}, {27'd0, got.rs});
                    chk($sformatf("v%0d_exRt", i), {27'd0, exRt}, {27'd0, got.rt});
                end
            end
        end

        // Asynchronous reset while a load-use stall is pending.
        @(negedge clk);
        instruction = i_ins(6'h23, 1, 5, 16'h0000); ifidValid = 1'b1; exReady = 1'b1;
        flush = 1'b0; wbRegWrite = 1'b0;
        @(negedge clk);
        instruction = r_ins(5, 4, 6, 6'h20);
        #1;
        chk("midreset_stall_before", {31'd0, stall}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midreset_exValid", {31'd0, exValid}, 32'd0);
        chk("midreset_stallCount", {16'd0, stallCount}, 32'd0);
        chk("midreset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("postreset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("postreset_exValid", {31'd0, exValid}, 32'd1);
        chk("postreset_exWriteAddress", {27'd0, exWriteAddress}, 32'd6);
        chk("postreset_stallCount", {16'd0, stallCount}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
